// File: rtl/conv_pkg.sv
// Shared FSM state encoding and default geometry for the convolution window sequencer.
package conv_pkg;
    localparam int DEF_IMAGE_DIM   = 4;
    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_ADDR_SIZE   = 4;
    localparam int DEF_CNT_WIDTH   = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT_ACK,
        ST_DONE
    } conv_state_t;
endpackage

// File: rtl/conv_tap_counter.sv
// Kernel row/column walker (kc fastest); advances one tap per enabled cycle and wraps after the last.
// Flags are combinational from the current count, so they describe the tap about to be issued.
module conv_tap_counter
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int W           = DEF_ADDR_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] kr,
    output logic [W-1:0] kc,
    output logic         is_first,
    output logic         is_last
);
    localparam logic [W-1:0] K_MAX = W'(KERNEL_SIZE - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            kr <= '0;
            kc <= '0;
        end else if (en) begin
            if (kc == K_MAX) begin
                kc <= '0;
                kr <= (kr == K_MAX) ? '0 : kr + W'(1);
            end else begin
                kc <= kc + W'(1);
            end
        end
    end

    assign is_first = (kr == '0) && (kc == '0);
    assign is_last  = (kr == K_MAX) && (kc == K_MAX);
endmodule

// File: rtl/conv_window_seq.sv
// Walks every output pixel's KxK window, issuing one registered tap per non-stalled cycle, then
// holds out_req until out_ack; stall freezes taps only, frame_cnt==0 while busy sets sticky overrun.
module conv_window_seq
    import conv_pkg::*;
#(
    parameter int IMAGE_DIM   = DEF_IMAGE_DIM,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] frame_cnt,
    input  logic                 stall,
    output logic [ADDR_SIZE-1:0] img_addr,
    output logic [ADDR_SIZE-1:0] ker_addr,
    output logic                 tap_valid,
    output logic                 tap_first,
    output logic                 tap_last,
    output logic [ADDR_SIZE-1:0] out_idx,
    output logic                 out_req,
    input  logic                 out_ack,
    output logic                 frame_done,
    output logic                 overrun
);
    localparam int OUT_DIM = IMAGE_DIM - KERNEL_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0] IMG_DIM_A = ADDR_SIZE'(IMAGE_DIM);
    localparam logic [ADDR_SIZE-1:0] KER_DIM_A = ADDR_SIZE'(KERNEL_SIZE);
    localparam logic [ADDR_SIZE-1:0] OCOL_MAX  = ADDR_SIZE'(OUT_DIM - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_IDX  = ADDR_SIZE'(OUT_DIM * OUT_DIM - 1);

    conv_state_t          state, state_d;
    logic [ADDR_SIZE-1:0] orow, ocol, kr, kc;
    logic [ADDR_SIZE-1:0] orow_sel, ocol_sel, row_sum, col_sum;
    logic                 k_first, k_last;
    logic                 frame_start, launch, run_issue, ack_issue, issue;
    logic                 ack_take, final_out;

    assign frame_start = (frame_cnt == '0);
    assign ack_take    = (state == ST_WAIT_ACK) && out_req && out_ack;
    assign final_out   = (out_idx == LAST_IDX);

    conv_tap_counter #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .W           (ADDR_SIZE)
    ) u_tap_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (launch),
        .en       (issue),
        .kr       (kr),
        .kc       (kc),
        .is_first (k_first),
        .is_last  (k_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // An accepted result immediately issues the first tap of the next output window,
    // so the window position used for that tap is the advanced one.
    always_comb begin
        state_d   = state;
        launch    = 1'b0;
        run_issue = 1'b0;
        ack_issue = 1'b0;
        orow_sel  = orow;
        ocol_sel  = ocol;
        unique case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    launch  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    run_issue = 1'b1;
                    if (k_last) state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_take) begin
                    if (final_out) begin
                        state_d = ST_DONE;
                    end else begin
                        ack_issue = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (ack_issue) begin
            if (ocol == OCOL_MAX) begin
                ocol_sel = '0;
                orow_sel = orow + ADDR_SIZE'(1);
            end else begin
                ocol_sel = ocol + ADDR_SIZE'(1);
            end
        end
    end

    assign issue   = run_issue || ack_issue;
    assign row_sum = orow_sel + kr;
    assign col_sum = ocol_sel + kc;

    always_ff @(posedge clk) begin
        if (rst) begin
            img_addr   <= '0;
            ker_addr   <= '0;
            tap_valid  <= 1'b0;
            tap_first  <= 1'b0;
            tap_last   <= 1'b0;
            out_idx    <= '0;
            out_req    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            orow       <= '0;
            ocol       <= '0;
        end else begin
            tap_valid  <= issue;
            tap_first  <= issue && k_first;
            tap_last   <= issue && k_last;
            out_req    <= (state == ST_WAIT_ACK) && !ack_take;
            frame_done <= ack_take && final_out;
            if (issue) begin
                img_addr <= row_sum * IMG_DIM_A + col_sum;
                ker_addr <= kr * KER_DIM_A + kc;
            end
            if (launch) begin
                orow    <= '0;
                ocol    <= '0;
                out_idx <= '0;
            end else if (ack_issue) begin
                orow    <= orow_sel;
                ocol    <= ocol_sel;
                out_idx <= out_idx + ADDR_SIZE'(1);
            end
            if (frame_start && (state != ST_IDLE)) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_window_seq.sv
// Directed and randomized checks of conv_window_seq against a tap-list scoreboard and
// handshake-level timing rules (tap order, out_req/out_ack, frame_done, overrun, reset).
module tb_conv_window_seq;
    localparam int IMG = 4;
    localparam int K   = 3;
    localparam int AW  = 4;
    localparam int CW  = 10;
    localparam int OD  = IMG - K + 1;
    localparam int NT  = OD * OD * K * K;
    localparam logic [AW-1:0] LAST_IDX = AW'(OD * OD - 1);

    typedef struct packed {
        logic [AW-1:0] img;
        logic [AW-1:0] ker;
        logic          first;
        logic          last;
        logic [AW-1:0] idx;
    } tap_t;

    logic          clk;
    logic          rst;
    logic [CW-1:0] frame_cnt;
    logic          stall;
    logic [AW-1:0] img_addr, ker_addr, out_idx;
    logic          tap_valid, tap_first, tap_last;
    logic          out_req, out_ack, frame_done, overrun;

    conv_window_seq #(
        .IMAGE_DIM   (IMG),
        .KERNEL_SIZE (K),
        .ADDR_SIZE   (AW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_cnt  (frame_cnt),
        .stall      (stall),
        .img_addr   (img_addr),
        .ker_addr   (ker_addr),
        .tap_valid  (tap_valid),
        .tap_first  (tap_first),
        .tap_last   (tap_last),
        .out_idx    (out_idx),
        .out_req    (out_req),
        .out_ack    (out_ack),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tap_t          exp_q[$];
    int            n_assert, n_fail;
    int            cyc, launch_cyc, done_cyc, taps_seen, req_cycles, done_count;
    logic          busy, exp_overrun, waiting_first;
    logic          p_tv, p_tl, p_req, p_done;
    logic [AW-1:0] p_idx;
    logic [AW-1:0] obs_img[NT];
    logic [AW-1:0] obs_ker[NT];
    int            a_tbl[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Expected tap stream of one frame, straight from the window geometry.
    function automatic void build_frame();
        tap_t t;
        exp_q.delete();
        for (int o = 0; o < OD * OD; o++)
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) begin
                    t.img   = AW'((o / OD + r) * IMG + (o % OD + c));
                    t.ker   = AW'(r * K + c);
                    t.first = (r == 0) && (c == 0);
                    t.last  = (r == K - 1) && (c == K - 1);
                    t.idx   = AW'(o);
                    exp_q.push_back(t);
                end
    endfunction

    task automatic tick();
        logic s_stall, s_ack, s_rst, s_fz, launched;
        tap_t t;
        s_stall  = stall;
        s_ack    = out_ack;
        s_rst    = rst;
        s_fz     = (frame_cnt == '0);
        launched = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            check("reset_outputs", 32'({img_addr, ker_addr, tap_valid, tap_first, tap_last,
                                         out_idx, out_req, frame_done, overrun}), 32'(0));
            exp_q.delete();
            busy          = 1'b0;
            exp_overrun   = 1'b0;
            waiting_first = 1'b0;
        end else begin
            if (s_fz && !busy) begin
                busy       = 1'b1;
                launched   = 1'b1;
                build_frame();
                launch_cyc = cyc;
                taps_seen  = 0;
                req_cycles = 0;
                check("launch_cycle_no_tap", 32'(tap_valid), 32'(0));
            end else if (s_fz) begin
                exp_overrun = 1'b1;
            end
            if (p_done) busy = 1'b0;
            check("overrun", 32'(overrun), 32'(exp_overrun));
            check("req_tap_exclusive", 32'(out_req && tap_valid), 32'(0));
            check("out_req", 32'(out_req), 32'((p_tv && p_tl) || (p_req && !s_ack)));
            check("frame_done", 32'(frame_done), 32'(p_req && s_ack && (p_idx == LAST_IDX)));
            if (p_tv && !p_tl && !s_stall) check("no_bubble", 32'(tap_valid), 32'(1));
            if (waiting_first && !s_stall) check("first_tap_after_launch", 32'(tap_valid), 32'(1));
            if (tap_valid && s_stall) check("tap_under_stall", 32'(p_req && s_ack), 32'(1));
            if (p_req && s_ack && (p_idx != LAST_IDX))
                check("next_output_starts", 32'(tap_valid && tap_first), 32'(1));
            if (p_req && out_req) check("out_idx_held", 32'(out_idx), 32'(p_idx));
            if (tap_valid) begin
                waiting_first = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_tap", 32'(tap_valid), 32'(0));
                end else begin
                    t = exp_q.pop_front();
                    check("tap", 32'({img_addr, ker_addr, tap_first, tap_last, out_idx}), 32'(t));
                    if (taps_seen < NT) begin
                        obs_img[taps_seen] = img_addr;
                        obs_ker[taps_seen] = ker_addr;
                    end
                    taps_seen++;
                end
            end
            if (launched) waiting_first = 1'b1;
            if (out_req) req_cycles++;
            if (frame_done) begin
                done_cyc = cyc;
                done_count++;
                check("frame_taps_complete", 32'(taps_seen), 32'(NT));
            end
        end
        p_tv   = tap_valid;
        p_tl   = tap_last;
        p_req  = out_req;
        p_done = frame_done;
        p_idx  = out_idx;
    endtask

    task automatic launch();
        frame_cnt = '0;
        tick();
        frame_cnt = CW'($urandom_range(199, 1));
    endtask

    task automatic finish_frame(input string tag);
        for (int i = 0; i < 2000 && !frame_done; i++) tick();
        check(tag, 32'(frame_done), 32'(1));
    endtask

    task automatic wait_taps(input int n);
        for (int i = 0; i < 500 && taps_seen < n; i++) tick();
    endtask

    initial begin
        int d0;
        n_assert = 0; n_fail = 0; cyc = 0; done_count = 0;
        launch_cyc = 0; done_cyc = 0; taps_seen = 0; req_cycles = 0;
        busy = 0; exp_overrun = 0; waiting_first = 0;
        p_tv = 0; p_tl = 0; p_req = 0; p_done = 0; p_idx = '0;
        rst = 1'b1; frame_cnt = 10'd5; stall = 1'b0; out_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Zero stall, ack tied high.
        out_ack = 1'b1;
        launch();
        finish_frame("A_done_seen");
        check("A_latency", 32'(done_cyc - launch_cyc), 32'(41));
        for (int i = 0; i < 9; i++) check("A_out0_img", 32'(obs_img[i]), 32'(a_tbl[i]));
        check("A_out3_start_img", 32'(obs_img[27]), 32'(5));
        check("A_req_cycles", 32'(req_cycles), 32'(4));
        repeat (3) tick();

        // Three stall cycles after the 4th tap of output 1.
        launch();
        wait_taps(13);
        stall = 1'b1;
        repeat (3) begin
            tick();
            check("B_stall_no_tap", 32'(tap_valid), 32'(0));
        end
        stall = 1'b0;
        tick();
        check("B_resume_valid", 32'(tap_valid), 32'(1));
        check("B_resume_img", 32'(img_addr), 32'(6));
        check("B_resume_ker", 32'(ker_addr), 32'(4));
        finish_frame("B_done_seen");
        check("B_latency", 32'(done_cyc - launch_cyc), 32'(44));
        repeat (3) tick();

        // Consumer withholds ack for 5 cycles on output 2.
        launch();
        wait_taps(27);
        out_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("C_req_held", 32'(out_req), 32'(1));
            check("C_idx_held", 32'(out_idx), 32'(2));
            check("C_no_tap", 32'(tap_valid), 32'(0));
        end
        out_ack = 1'b1;
        tick();
        check("C_req_dropped", 32'(out_req), 32'(0));
        finish_frame("C_done_seen");
        check("C_latency", 32'(done_cyc - launch_cyc), 32'(45));
        check("C_req_cycles", 32'(req_cycles), 32'(8));
        repeat (3) tick();

        // Stray acks while out_req is low, including right after each last tap.
        out_ack = 1'b0;
        launch();
        for (int i = 0; i < 300 && !frame_done; i++) begin
            out_ack = out_req || tap_last || ($urandom_range(0, 1) == 1);
            tick();
        end
        check("D_done_seen", 32'(frame_done), 32'(1));
        check("D_latency", 32'(done_cyc - launch_cyc), 32'(41));
        check("D_req_cycles", 32'(req_cycles), 32'(4));
        out_ack = 1'b1;
        repeat (3) tick();

        // Frame start while busy: sticky overrun, frame unaffected.
        launch();
        wait_taps(5);
        frame_cnt = '0;
        tick();
        frame_cnt = 10'd77;
        check("E_overrun_set", 32'(overrun), 32'(1));
        finish_frame("E_done_seen");
        check("E_latency", 32'(done_cyc - launch_cyc), 32'(41));
        repeat (5) tick();
        check("E_overrun_sticky", 32'(overrun), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("E_overrun_cleared", 32'(overrun), 32'(0));

        // Reset in the middle of output 1 aborts the frame.
        launch();
        wait_taps(12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0 = done_count;
        repeat (30) tick();
        check("F_no_frame_done", 32'(done_count), 32'(d0));
        check("F_idle_no_tap", 32'(tap_valid), 32'(0));
        launch();
        wait_taps(1);
        check("F_restart_img", 32'(obs_img[0]), 32'(0));
        finish_frame("F_done_seen");
        repeat (3) tick();

        // Randomized stall and ack.
        for (int f = 0; f < 6; f++) begin
            launch();
            for (int i = 0; i < 1500 && !frame_done; i++) begin
                stall     = ($urandom_range(0, 3) == 0);
                out_ack   = ($urandom_range(0, 1) == 1);
                frame_cnt = CW'($urandom_range(199, 1));
                tick();
            end
            check("R_done_seen", 32'(frame_done), 32'(1));
            stall = 1'b0;
            repeat (3) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
